// File: rtl/ysyx_25010008_axil_mem.sv
// AXI4-Lite slave memory placed after the LSU: word array, byte strobes,
// programmable response latency, SLVERR for addresses outside the array.
// Optional macro YSYX_AXIL_MEM_RAND_DELAY_EN adds 0-7 extra cycles per
// response, taken from an 8-bit LFSR seeded on reset.
`timescale 1ns/1ps
module ysyx_25010008_axil_mem #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 65536,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = $clog2(LATENCY + 8) + 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_e;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic addr_ok(input logic [31:0] a);
    return (a >= ADDR_BASE) && (((a - ADDR_BASE) >> 2) < 32'(DEPTH_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return IDX_W'((a - ADDR_BASE) >> 2);
  endfunction

  logic [CNT_W-1:0] lat_load;

`ifdef YSYX_AXIL_MEM_RAND_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 8,6,5,4, free-running from reset
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // LFSR register, deterministic seed
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end

  // counter load value with random extra delay
  always_comb lat_load = CNT_W'(LATENCY) + CNT_W'(lfsr_q[2:0]);
`else
  // counter load value, fixed latency
  always_comb lat_load = CNT_W'(LATENCY);
`endif

  // ---------------- read channel ----------------
  rd_state_e        rd_state_q, rd_state_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [31:0]      ar_addr_q, ar_addr_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

  // read FSM next state and registered outputs
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    ar_addr_d  = ar_addr_q;
    rd_cnt_d   = rd_cnt_q;
    unique case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          ar_addr_d  = araddr;
          arready_d  = 1'b0;
          rd_cnt_d   = lat_load;
          rd_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_cnt_q != '0) begin
          rd_cnt_d = rd_cnt_q - 1'b1;
        end else begin
          if (addr_ok(ar_addr_q)) begin
            rdata_d = mem[addr_idx(ar_addr_q)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
          rvalid_d   = 1'b1;
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (rready && rvalid_q) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // read FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      ar_addr_q  <= '0;
      rd_cnt_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      ar_addr_q  <= ar_addr_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  // ---------------- write channel ----------------
  wr_state_e        wr_state_q, wr_state_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             aw_got_q, aw_got_d;
  logic             w_got_q, w_got_d;
  logic [31:0]      aw_addr_q, aw_addr_d;
  logic [31:0]      w_data_q, w_data_d;
  logic [3:0]       w_strb_q, w_strb_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             mem_we;

  // write FSM next state, registered outputs and commit strobe
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    wr_cnt_d   = wr_cnt_q;
    mem_we     = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          aw_got_d  = 1'b1;
          aw_addr_d = awaddr;
        end
        if (wvalid && wready_q) begin
          w_got_d  = 1'b1;
          w_data_d = wdata;
          w_strb_d = wstrb;
        end
        // each ready follows its own latch flag; both set means leave idle
        if (aw_got_d && w_got_d) begin
          aw_got_d   = 1'b0;
          w_got_d    = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          wr_cnt_d   = lat_load;
          wr_state_d = W_WAIT;
        end else begin
          awready_d = !aw_got_d;
          wready_d  = !w_got_d;
        end
      end
      W_WAIT: begin
        if (wr_cnt_q != '0) begin
          wr_cnt_d = wr_cnt_q - 1'b1;
        end else begin
          mem_we     = addr_ok(aw_addr_q);
          bresp_d    = addr_ok(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
          bvalid_d   = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready && bvalid_q) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // write FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // byte-masked array update; reset suppresses a pending commit
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_strb_q[i]) mem[addr_idx(aw_addr_q)][8*i +: 8] <= w_data_q[8*i +: 8];
      end
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_ysyx_25010008_axil_mem.sv
// Bench for ysyx_25010008_axil_mem: directed cases plus randomized traffic,
// every output checked each cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_ysyx_25010008_axil_mem;

  localparam int unsigned LAT   = 1;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned DEPTH = 65536;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  ysyx_25010008_axil_mem #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mm [int unsigned];
  bit          started = 0;
  int unsigned cyc = 0;
  logic        m_arready = 0, m_rvalid = 0, m_awready = 0, m_wready = 0, m_bvalid = 0;
  logic [31:0] m_rdata = 0;
  logic [1:0]  m_rresp = 0, m_bresp = 0;
  bit          m_rz = 0, m_bz = 0;
  bit          rd_pend = 0, wr_pend = 0, aw_got = 0, w_got = 0;
  int unsigned rd_due, wr_due;
  logic [31:0] rd_a, wr_a, wr_d;
  logic [3:0]  wr_s;

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < DEPTH);
  endfunction

  initial begin
    logic [31:0] old;
    int unsigned key;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_rz = 1; m_bz = 1;
        rd_pend = 0; wr_pend = 0; aw_got = 0; w_got = 0;
      end else begin
        // read side first: a read sampled at a commit edge sees old data
        if (m_rvalid) begin
          if (rready) begin m_rvalid = 0; m_arready = 1; end
        end else if (rd_pend) begin
          if (cyc == rd_due) begin
            key = (rd_a - BASE) >> 2;
            if (in_rng(rd_a)) begin
              m_rdata = mm.exists(key) ? mm[key] : 32'h0;
              m_rresp = 2'b00;
            end else begin
              m_rdata = 0;
              m_rresp = 2'b10;
            end
            m_rvalid = 1; m_rz = 0; rd_pend = 0;
          end
        end else if (m_arready && arvalid) begin
          rd_pend = 1; rd_due = cyc + 1 + LAT; rd_a = araddr; m_arready = 0;
        end else begin
          m_arready = 1;
        end
        // write side
        if (m_bvalid) begin
          if (bready) begin m_bvalid = 0; m_awready = 1; m_wready = 1; end
        end else if (wr_pend) begin
          if (cyc == wr_due) begin
            key = (wr_a - BASE) >> 2;
            if (in_rng(wr_a)) begin
              old = mm.exists(key) ? mm[key] : 32'h0;
              for (int b = 0; b < 4; b++)
                if (wr_s[b]) old[8*b +: 8] = wr_d[8*b +: 8];
              mm[key] = old;
              m_bresp = 2'b00;
            end else begin
              m_bresp = 2'b10;
            end
            m_bvalid = 1; m_bz = 0; wr_pend = 0;
          end
        end else begin
          if (m_awready && awvalid) begin aw_got = 1; wr_a = awaddr; end
          if (m_wready && wvalid) begin w_got = 1; wr_d = wdata; wr_s = wstrb; end
          if (aw_got && w_got) begin
            wr_pend = 1; wr_due = cyc + 1 + LAT;
            aw_got = 0; w_got = 0; m_awready = 0; m_wready = 0;
          end else begin
            m_awready = !aw_got; m_wready = !w_got;
          end
        end
      end
      started = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("arready", 32'(arready), 32'(m_arready));
        chk("rvalid",  32'(rvalid),  32'(m_rvalid));
        chk("awready", 32'(awready), 32'(m_awready));
        chk("wready",  32'(wready),  32'(m_wready));
        chk("bvalid",  32'(bvalid),  32'(m_bvalid));
        if (m_rvalid || m_rz) begin
          chk("rdata", rdata, m_rdata);
          chk("rresp", 32'(rresp), 32'(m_rresp));
        end
        if (m_bvalid || m_bz) chk("bresp", 32'(bresp), 32'(m_bresp));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output int lat, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, ha, hw;
    lat = -1; resp = 2'b11;
    bready = (b_dly == 0) && ($urandom_range(0, 1) == 1);
    for (int k = 0; k < 64 && !(aw_done && w_done); k++) begin
      if (!aw_done && k >= aw_dly) begin awvalid = 1; awaddr = a; end
      if (!w_done && k >= w_dly) begin wvalid = 1; wdata = d; wstrb = s; end
      @(negedge clk);
      ha = awvalid && awready;
      hw = wvalid && wready;
      @(posedge clk); #1;
      if (ha) begin awvalid = 0; aw_done = 1; end
      if (hw) begin wvalid = 0; w_done = 1; end
    end
    if (!(aw_done && w_done)) begin
      timeout("aw_w_handshake");
      awvalid = 0; wvalid = 0; bready = 0;
      return;
    end
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bvalid && lat < 64);
    if (!bvalid) begin timeout("bvalid"); bready = 0; return; end
    resp = bresp;
    for (int k = 0; k < b_dly; k++) begin @(posedge clk); #1; end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input int r_dly,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    bit h, done = 0;
    lat = -1; data = 32'hxxxx_xxxx; resp = 2'b11;
    rready = (r_dly == 0) && ($urandom_range(0, 1) == 1);
    arvalid = 1; araddr = a;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      h = arvalid && arready;
      @(posedge clk); #1;
      if (h) begin arvalid = 0; done = 1; end
    end
    if (!done) begin timeout("ar_handshake"); arvalid = 0; rready = 0; return; end
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!rvalid && lat < 64);
    if (!rvalid) begin timeout("rvalid"); rready = 0; return; end
    data = rdata; resp = rresp;
    for (int k = 0; k < r_dly; k++) begin @(posedge clk); #1; end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic pulse_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] pool [8];
  logic [31:0] oor  [3];

  initial begin
    logic [31:0] d;
    logic [1:0]  rs;
    int          lt;
    logic [31:0] d2;
    logic [1:0]  rs2;
    int          lt2;

    rst = 1; arvalid = 0; araddr = 0; rready = 0;
    awvalid = 0; awaddr = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", 32'(arready), 0);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_rvalid",  32'(rvalid), 0);
    chk("rst_rdata",   rdata, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("ready_rise_ar", 32'(arready), 1);
    chk("ready_rise_w",  32'(wready), 1);

    // basic write/read with latency 1
    do_write(32'h8000_0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, lt, rs);
    chk("wr_lat", 32'(lt), 2);
    chk("wr_resp", 32'(rs), 0);
    do_read(32'h8000_0010, 0, d, rs, lt);
    chk("rd_lat", 32'(lt), 2);
    chk("rd_data", d, 32'hDEADBEEF);
    chk("rd_resp", 32'(rs), 0);

    // byte strobes
    do_write(32'h8000_0020, 32'h11223344, 4'hF, 0, 0, 0, lt, rs);
    do_write(32'h8000_0020, 32'hAABBCCDD, 4'b0100, 0, 0, 1, lt, rs);
    do_read(32'h8000_0020, 0, d, rs, lt);
    chk("strb_data", d, 32'h11BB3344);
    do_write(32'h8000_0020, 32'h99999999, 4'b0000, 0, 0, 0, lt, rs);
    chk("strb0_resp", 32'(rs), 0);
    do_read(32'h8000_0023, 1, d, rs, lt);
    chk("strb0_data", d, 32'h11BB3344);

    // W three cycles ahead of AW
    do_write(32'h8000_0030, 32'hCAFEF00D, 4'hF, 3, 0, 0, lt, rs);
    chk("w_first_lat", 32'(lt), 2);
    do_read(32'h8000_0030, 0, d, rs, lt);
    chk("w_first_data", d, 32'hCAFEF00D);

    // read backpressure
    do_read(32'h8000_0010, 5, d, rs, lt);
    chk("bp_data", d, 32'hDEADBEEF);
    chk("bp_rvalid_low", 32'(rvalid), 0);
    chk("bp_arready_high", 32'(arready), 1);

    // out of range; 8004_0000 would alias word 0 if the range check were lost
    do_write(32'h8000_0000, 32'h0BADF00D, 4'hF, 0, 0, 0, lt, rs);
    do_read(32'h7FFF_FFFC, 0, d, rs, lt);
    chk("oor_lo_resp", 32'(rs), 2);
    chk("oor_lo_data", d, 0);
    do_read(32'h8004_0000, 0, d, rs, lt);
    chk("oor_hi_resp", 32'(rs), 2);
    chk("oor_hi_data", d, 0);
    do_write(32'h8004_0000, 32'h12345678, 4'hF, 0, 0, 0, lt, rs);
    chk("oor_wr_resp", 32'(rs), 2);
    do_read(32'h8000_0000, 0, d, rs, lt);
    chk("oor_no_alias", d, 32'h0BADF00D);
    do_write(32'h8003_FFFC, 32'hFEEDFACE, 4'hF, 0, 0, 0, lt, rs);
    do_read(32'h8003_FFFC, 0, d, rs, lt);
    chk("last_word_resp", 32'(rs), 0);
    chk("last_word_data", d, 32'hFEEDFACE);

    // reset during read wait
    arvalid = 1; araddr = 32'h8000_0010;
    @(posedge clk); #1;
    arvalid = 0;
    pulse_reset();
    repeat (4) @(posedge clk);
    #1;
    chk("rst_rd_no_resp", 32'(rvalid), 0);

    // reset with AW latched, W pending
    awvalid = 1; awaddr = 32'h8000_0030;
    @(posedge clk); #1;
    awvalid = 0;
    chk("aw_only_wready", 32'(wready), 1);
    pulse_reset();
    do_write(32'h8000_0034, 32'h01020304, 4'hF, 0, 0, 0, lt, rs);
    do_read(32'h8000_0030, 0, d, rs, lt);
    chk("rst_aw_mem", d, 32'hCAFEF00D);

    // reset with both latched, before the commit edge
    awvalid = 1; awaddr = 32'h8000_0020; wvalid = 1; wdata = 32'h55555555; wstrb = 4'hF;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    pulse_reset();
    do_read(32'h8000_0020, 0, d, rs, lt);
    chk("rst_wait_mem", d, 32'h11BB3344);
    chk("rst_wait_bvalid", 32'(bvalid), 0);

    // randomized traffic
    pool[0] = BASE;
    pool[1] = BASE + 32'h4;
    pool[2] = BASE + 32'h100;
    pool[3] = BASE + 32'h104;
    pool[4] = BASE + 32'h1_0000;
    pool[5] = BASE + 32'h2_FFF8;
    pool[6] = BASE + 32'h3_FFFC;
    pool[7] = BASE + 32'h40;
    oor[0] = 32'h7FFF_FFFC;
    oor[1] = 32'h8004_0000;
    oor[2] = 32'hFFFF_FFF0;
    for (int i = 0; i < 8; i++)
      do_write(pool[i], $urandom, 4'hF, 0, 0, 0, lt, rs);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a, b;
      a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      b = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), lt, rs);
        1: do_read(a, $urandom_range(0, 3), d, rs, lt);
        2: fork
             do_read(a, $urandom_range(0, 2), d, rs, lt);
             do_write(b, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(0, 2), lt2, rs2);
           join
        default: begin
          if ($urandom_range(0, 1) == 1)
            do_read(oor[$urandom_range(0, 2)], 0, d, rs, lt);
          else
            do_write(oor[$urandom_range(0, 2)], $urandom, 4'hF, 0, 0, 0, lt, rs);
        end
      endcase
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/ysyx_25010008_axil_mem.md
Name: ysyx_25010008_axil_mem

Overview:
AXI4-Lite slave memory that sits directly downstream of the LSU and answers its read (AR/R) and write (AW/W/B) channels. It holds a word-addressed array, applies byte strobes on writes and inserts a programmable access latency. It flags out-of-range addresses with an error response. It replaces a zero-latency behavioural store, so the LSU handshake FSM is exercised under realistic timing.

Parameters:
ADDR_BASE  32'h8000_0000  byte address of word 0
DEPTH_WORDS  65536  number of 32-bit words in the array
LATENCY  1  cycles between address/data acceptance and response valid (0 allowed)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous active-high reset
araddr  in  32  read byte address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  32  read data
rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR
rvalid  out  1  read data valid
rready  in  1  master accepts read data
awaddr  in  32  write byte address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  32  write data, lane-aligned by master
wstrb  in  4  byte enables, bit i selects wdata[8i+7:8i]
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response, same encoding as rresp
bvalid  out  1  write response valid
bready  in  1  master accepts write response

Behaviour:
- Reset: every output 0 (arready, awready, wready, rvalid, bvalid, rdata, rresp, bresp). Both FSMs go to IDLE. Readies rise on the first cycle after rst falls. Array contents are not cleared.
- All outputs are registered. A handshake completes on a rising edge where valid & ready are both 1.
- Index = (addr - ADDR_BASE) >> 2, with addr[1:0] ignored. The address is in range iff addr >= ADDR_BASE and index < DEPTH_WORDS.
- Read FSM, one outstanding read:
  - R_IDLE: arready=1. On AR handshake, latch the address, arready<=0, counter<=LATENCY, go to R_WAIT.
  - R_WAIT: decrement the counter while it is nonzero. When it is 0, sample the array: rdata<=mem[index] and rresp<=OKAY, or rdata<=0 and rresp<=SLVERR if out of range. Then rvalid<=1 and go to R_RESP.
  - Timing: AR handshake at edge T gives rvalid=1 after edge T+1+LATENCY.
  - R_RESP: rdata, rresp and rvalid are held stable until rready. On R handshake, rvalid<=0 and arready<=1 in the same edge, back to R_IDLE.
- Write FSM, one outstanding write:
  - W_IDLE: awready=1 and wready=1. The AW and W handshakes are independent and may occur in either order or in the same cycle.
  - Each ready drops on the edge of its own handshake, latching address or data+strobe respectively.
  - When both are latched, counter<=LATENCY and go to W_WAIT.
  - W_WAIT: count down to 0, then commit mem[index] bytes where wstrb[i]=1, unmasked bytes unchanged. bresp<=OKAY, or SLVERR with no write if out of range. bvalid<=1, go to W_RESP.
  - Timing: the later of AW/W handshakes at edge T gives bvalid after edge T+1+LATENCY.
  - W_RESP: bvalid is held until bready. On B handshake, bvalid<=0 and awready=wready=1, back to W_IDLE.
- Read and write FSMs run concurrently. If a read samples in the same cycle a write commits to the same word, the read returns pre-write data.
- wstrb=4'b0000 is a legal write: OKAY response, memory unchanged.
- Reset mid-operation: transaction dropped, no pending response. A write not yet committed does not modify memory.
- rready or bready held high early has no effect until the corresponding valid is 1.

Optional Feature:
YSYX_AXIL_MEM_RAND_DELAY_EN:
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded 8'hA5 on reset, advances every cycle. Each counter load uses LATENCY + lfsr[2:0], so each response arrives after an extra 0-7 cycles. The sequence is deterministic from reset.
- Undefined: the LFSR is absent and latency is exactly LATENCY.

Test Plan:
- LATENCY=1: write 32'hDEADBEEF to 32'h8000_0010 with wstrb=4'hF -> bvalid 2 cycles after the handshake, bresp=00. Read the same address -> rvalid 2 cycles after AR, rdata=32'hDEADBEEF, rresp=00.
- Byte strobe: word holds 32'h11223344; write wdata=32'hAABBCCDD, wstrb=4'b0100 -> readback 32'h11BB3344. Write wstrb=4'b0000 -> readback unchanged.
- W handshake 3 cycles before AW -> wready low after W, awready still high; bvalid follows the AW edge by 1+LATENCY cycles; data committed correctly.
- Backpressure: hold rready=0 for 5 cycles after rvalid -> rdata/rresp stable, arready stays 0; rready=1 -> rvalid=0 and arready=1 next edge.
- Out of range: read 32'h7FFF_FFFC and 32'h8004_0000 (DEPTH 65536) -> rresp=10, rdata=0. Write 32'h8004_0000 -> bresp=10, no array word changed.
- Assert rst during R_WAIT and with AW latched but W pending -> all outputs 0 next cycle, memory unchanged, fresh transactions complete normally.
